// File: rtl/fpu_seq_divider.sv
// Purpose : multi-cycle floating-point divider, radix-2 restoring, one quotient bit per clock, RNE.
// Latency : MAN_W+6 cycles for normal operands, 2 cycles for special cases (counting the accept cycle).
// Backpressure: in_ready only in IDLE; result/flags held in DONE until out_ready; one op in flight.
//
// Ports:
//   CLK, RESET_N          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     operand handshake (a_operand dividend, b_operand divisor)
//   out_valid/out_ready   result handshake (result quotient, flags {invalid, div_by_zero, overflow, underflow})
//   busy                  high whenever the divider is not idle
module fpu_seq_divider #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W+MAN_W:0]     a_operand,
  input  logic [EXP_W+MAN_W:0]     b_operand,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     result,
  output logic [3:0]               flags,
  output logic                     busy
);

  localparam int W       = 1 + EXP_W + MAN_W;
  localparam int BIAS    = 2**(EXP_W-1) - 1;
  localparam int EXP_MAX = 2**EXP_W - 1;
  localparam int Q       = MAN_W + 3;   // integer bit, fraction, guard, round
  localparam int CW      = $clog2(Q);
  localparam int RW      = MAN_W + 3;   // remainder width: rem < 2*mb always

  typedef enum logic [2:0] {IDLE, PREP, DIV, ROUND, DONE} state_t;

  state_t state_q, state_d;

  logic [W-1:0]         a_q, b_q;
  logic                 sign_q;
  logic [EXP_W+1:0]     exp_q;          // two's complement, read as signed
  logic [RW-1:0]        rem_q, mb_q;
  logic [Q-1:0]         quo_q;
  logic [CW-1:0]        cnt_q;
  logic [W-1:0]         result_q;
  logic [3:0]           flags_q;

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign flags     = flags_q;

  // ---------------- unpack / special-case detection ----------------
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic             sgn;
  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic             spec_hit;
  logic [W-1:0]     spec_res;
  logic [3:0]       spec_flags;
  logic [RW-1:0]    ma_ext, mb_ext, ma_adj;
  logic             e_adj;
  logic [EXP_W+1:0] exp_prep;

  always_comb begin
    ea  = a_q[W-2:MAN_W];
    eb  = b_q[W-2:MAN_W];
    fa  = a_q[MAN_W-1:0];
    fb  = b_q[MAN_W-1:0];
    sgn = a_q[W-1] ^ b_q[W-1];
    // exponent field of zero means zero or subnormal; both treated as zero
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_inf  = (ea == '1) && (fa == '0);
    b_inf  = (eb == '1) && (fb == '0);
    a_nan  = (ea == '1) && (fa != '0);
    b_nan  = (eb == '1) && (fb != '0);

    spec_hit   = 1'b1;
    spec_res   = '0;
    spec_flags = '0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_res   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      spec_flags = 4'b1000;
    end else if (a_inf) begin
      spec_res = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (b_zero) begin
      spec_res   = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      spec_flags = 4'b0100;
    end else if (a_zero || b_inf) begin
      spec_res = {sgn, {(W-1){1'b0}}};
    end else begin
      spec_hit = 1'b0;
    end

    // pre-normalise so the first quotient bit is always 1
    ma_ext = {3'b001, fa};
    mb_ext = {3'b001, fb};
    e_adj  = (ma_ext < mb_ext);
    ma_adj = e_adj ? (ma_ext << 1) : ma_ext;
    exp_prep = {2'b00, ea} - {2'b00, eb} + (EXP_W+2)'(BIAS) - (EXP_W+2)'(e_adj);
  end

  // ---------------- restoring division step ----------------
  logic          ge;
  logic [RW-1:0] rem_nx;

  always_comb begin
    ge     = (rem_q >= mb_q);
    rem_nx = ge ? ((rem_q - mb_q) << 1) : (rem_q << 1);
  end

  // ---------------- round and pack ----------------
  logic             sticky, rnd_up, carry;
  logic [MAN_W+1:0] man_r;
  logic [EXP_W+1:0] exp_r;
  logic [W-1:0]     round_res;
  logic [3:0]       round_flags;

  always_comb begin
    sticky = (rem_q != '0);
    rnd_up = quo_q[1] && (quo_q[0] || sticky || quo_q[2]);
    man_r  = {1'b0, quo_q[Q-1:2]} + (MAN_W+2)'(rnd_up);
    carry  = man_r[MAN_W+1];
    exp_r  = exp_q + (EXP_W+2)'(carry);

    round_res   = {sign_q, exp_r[EXP_W-1:0], carry ? {MAN_W{1'b0}} : man_r[MAN_W-1:0]};
    round_flags = '0;
    if ($signed(exp_r) >= $signed((EXP_W+2)'(EXP_MAX))) begin
      round_res   = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      round_flags = 4'b0010;
    end else if ($signed(exp_r) < $signed((EXP_W+2)'(1))) begin
      round_res   = {sign_q, {(W-1){1'b0}}};
      round_flags = 4'b0001;
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = PREP;
      PREP:    state_d = spec_hit ? DONE : DIV;
      DIV:     if (cnt_q == CW'(Q-1)) state_d = ROUND;
      ROUND:   state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      a_q      <= '0;
      b_q      <= '0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      rem_q    <= '0;
      mb_q     <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q <= a_operand;
            b_q <= b_operand;
          end
        end
        PREP: begin
          sign_q <= sgn;
          exp_q  <= exp_prep;
          rem_q  <= ma_adj;
          mb_q   <= mb_ext;
          quo_q  <= '0;
          cnt_q  <= '0;
          if (spec_hit) begin
            result_q <= spec_res;
            flags_q  <= spec_flags;
          end
        end
        DIV: begin
          quo_q <= {quo_q[Q-2:0], ge};
          rem_q <= rem_nx;
          cnt_q <= cnt_q + 1'b1;
        end
        ROUND: begin
          result_q <= round_res;
          flags_q  <= round_flags;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_seq_divider.sv
module tb_fpu_seq_divider;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a_operand = '0;
  logic [31:0] b_operand = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic [3:0]  flags;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  fpu_seq_divider #(.EXP_W(8), .MAN_W(23)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_operand(a_operand), .b_operand(b_operand),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags), .busy(busy)
  );

  // Issue one operation and wait for out_valid; lat counts the accept cycle as 1.
  // Leaves the result pending (out_ready=0); lat=-1 means the op never completed.
  task automatic start_and_wait(input logic [31:0] a, input logic [31:0] b, output int lat);
    int cyc;
    int w;
    lat = -1;
    w = 0;
    while (!in_ready && w < 100) begin
      @(posedge CLK); #1; w++;
    end
    a_operand = a;
    b_operand = b;
    in_valid  = 1'b1;
    @(posedge CLK);
    cyc = 1;
    #1;
    in_valid = 1'b0;
    while (!out_valid && cyc < 100) begin
      @(posedge CLK); cyc++; #1;
    end
    if (out_valid) lat = cyc;
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(posedge CLK); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    #12;
    total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (result !== 32'h0)   begin bad++; $display("FAIL reset_result got=%h want=00000000", result); end
    total++; if (flags !== 4'h0)     begin bad++; $display("FAIL reset_flags got=%b want=0000", flags); end
    @(negedge CLK);
    RESET_N = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic test_normal();
    logic [31:0] av [3] = '{32'h40C00000, 32'h3F800000, 32'h40000000};
    logic [31:0] bv [3] = '{32'h40000000, 32'h40400000, 32'h40400000};
    logic [31:0] rv [3] = '{32'h40400000, 32'h3EAAAAAB, 32'h3F2AAAAB};
    int lat;
    for (int i = 0; i < 3; i++) begin
      start_and_wait(av[i], bv[i], lat);
      total++; if (lat !== 29)       begin bad++; $display("FAIL normal%0d_latency got=%0d want=29", i, lat); end
      total++; if (result !== rv[i]) begin bad++; $display("FAIL normal%0d_result got=%h want=%h", i, result, rv[i]); end
      total++; if (flags !== 4'b0000) begin bad++; $display("FAIL normal%0d_flags got=%b want=0000", i, flags); end
      take_result();
    end
  endtask

  task automatic test_special();
    logic [31:0] av [3] = '{32'hBF800000, 32'h00000000, 32'h7F800000};
    logic [31:0] bv [3] = '{32'h00000000, 32'h00000000, 32'h7F800000};
    logic [31:0] rv [3] = '{32'hFF800000, 32'h7FC00000, 32'h7FC00000};
    logic [3:0]  fv [3] = '{4'b0100, 4'b1000, 4'b1000};
    int lat;
    for (int i = 0; i < 3; i++) begin
      start_and_wait(av[i], bv[i], lat);
      total++; if (lat !== 2)        begin bad++; $display("FAIL special%0d_latency got=%0d want=2", i, lat); end
      total++; if (result !== rv[i]) begin bad++; $display("FAIL special%0d_result got=%h want=%h", i, result, rv[i]); end
      total++; if (flags !== fv[i])  begin bad++; $display("FAIL special%0d_flags got=%b want=%b", i, flags, fv[i]); end
      take_result();
    end
  endtask

  task automatic test_range();
    logic [31:0] av [2] = '{32'h7F7FFFFF, 32'h00800000};
    logic [31:0] bv [2] = '{32'h3F000000, 32'h4B000000};
    logic [31:0] rv [2] = '{32'h7F800000, 32'h00000000};
    logic [3:0]  fv [2] = '{4'b0010, 4'b0001};
    int lat;
    for (int i = 0; i < 2; i++) begin
      start_and_wait(av[i], bv[i], lat);
      total++; if (lat !== 29)       begin bad++; $display("FAIL range%0d_latency got=%0d want=29", i, lat); end
      total++; if (result !== rv[i]) begin bad++; $display("FAIL range%0d_result got=%h want=%h", i, result, rv[i]); end
      total++; if (flags !== fv[i])  begin bad++; $display("FAIL range%0d_flags got=%b want=%b", i, flags, fv[i]); end
      take_result();
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    // 6/2 in flight; a 1/3 offered while busy must be ignored
    a_operand = 32'h40C00000;
    b_operand = 32'h40000000;
    in_valid  = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      if (cyc == 3 || cyc == 12) begin
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready_busy got=%b want=0", in_ready); end
        a_operand = 32'h3F800000;
        b_operand = 32'h40400000;
        in_valid  = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge CLK); cyc++; #1;
    end
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_done_timeout got=%b want=1", out_valid); end
    for (int i = 0; i < 5; i++) begin
      a_operand = 32'h3F800000;
      b_operand = 32'h40400000;
      in_valid  = 1'b1;
      @(posedge CLK); #1;
      total++; if (out_valid !== 1'b1 || result !== 32'h40400000)
        begin bad++; $display("FAIL bp_hold%0d got=%b/%h want=1/40400000", i, out_valid, result); end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge CLK); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid got=%b want=0", out_valid); end
    total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL bp_release_ready got=%b want=1", in_ready); end
    @(posedge CLK); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_single_transfer got=%b want=0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_div();
    int lat;
    a_operand = 32'h3F800000;
    b_operand = 32'h40400000;
    in_valid  = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    // PREP edge, then 10 DIV edges
    repeat (11) @(posedge CLK);
    #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy_before got=%b want=1", busy); end
    RESET_N = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0)
      begin bad++; $display("FAIL mid_reset_ctrl got=%b%b%b want=010", busy, in_ready, out_valid); end
    total++; if (result !== 32'h0 || flags !== 4'h0)
      begin bad++; $display("FAIL mid_reset_data got=%h/%b want=00000000/0000", result, flags); end
    @(negedge CLK);
    RESET_N = 1'b1;
    @(posedge CLK); #1;
    start_and_wait(32'h40C00000, 32'h40000000, lat);
    total++; if (lat !== 29) begin bad++; $display("FAIL post_reset_latency got=%0d want=29", lat); end
    total++; if (result !== 32'h40400000 || flags !== 4'b0000)
      begin bad++; $display("FAIL post_reset_result got=%h/%b want=40400000/0000", result, flags); end
    take_result();
  endtask

  initial begin
    test_reset();
    test_normal();
    test_special();
    test_range();
    test_backpressure();
    test_reset_mid_div();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
